// File: rtl/rv32i_types.sv
// Shared types for the renamed pipeline: physical register file geometry and tag type.
package rv32i_types;

  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;

  typedef logic [5:0] ptag_t;

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical tags with speculative and architectural heads.
// Optional double-free / underflow checking is enabled by defining PHYS_FREE_LIST_CHECK_EN.
module phys_free_list
  import rv32i_types::*;
#(
  parameter int DEPTH = NUM_PHYS - NUM_ARCH,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output ptag_t            alloc_ptag,
  input  logic             commit_valid,
  input  logic             commit_has_dest,
  input  ptag_t            commit_old_ptag,
  input  logic             flush,
  output logic [PTR_W-1:0] free_count,
  output logic             err
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] spec_head_reg, arch_head_reg, tail_reg;
  logic [PTR_W-1:0] spec_head_next, arch_head_next, tail_next;
  ptag_t            mem_reg [DEPTH];
  logic             alloc_fire, commit_fire;

  // Pointers carry a wrap bit, so tail - spec_head is the free count even when full.
  assign free_count  = tail_reg - spec_head_reg;
  assign alloc_ready = (free_count != '0);
  assign alloc_ptag  = mem_reg[spec_head_reg[IDX_W-1:0]];

  assign alloc_fire  = alloc_req && alloc_ready && !flush;
  assign commit_fire = commit_valid && commit_has_dest;

  always_comb begin
    arch_head_next = arch_head_reg + PTR_W'(commit_fire);
    tail_next      = tail_reg + PTR_W'(commit_fire);
    // Recovery lands on the architectural head after this cycle's commit.
    spec_head_next = flush ? arch_head_next : spec_head_reg + PTR_W'(alloc_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_head_reg <= '0;
      arch_head_reg <= '0;
      tail_reg      <= PTR_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= ptag_t'(NUM_ARCH + i);
      end
    end else begin
      spec_head_reg <= spec_head_next;
      arch_head_reg <= arch_head_next;
      tail_reg      <= tail_next;
      if (commit_fire) begin
        mem_reg[tail_reg[IDX_W-1:0]] <= commit_old_ptag;
      end
    end
  end

`ifdef PHYS_FREE_LIST_CHECK_EN
  logic [NUM_PHYS-1:0] in_list_reg, in_list_next;
  logic                err_reg, err_next;
  logic [PTR_W-1:0]    restore_cnt, ptr_k;

  always_comb begin
    in_list_next = in_list_reg;
    restore_cnt  = tail_reg - spec_head_next;
    ptr_k        = '0;
    if (alloc_fire) begin
      in_list_next[alloc_ptag] = 1'b0;
    end
    // Entries from the restored head up to the old tail become free again.
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        ptr_k = spec_head_next + PTR_W'(k);
        if (PTR_W'(k) < restore_cnt) begin
          in_list_next[mem_reg[ptr_k[IDX_W-1:0]]] = 1'b1;
        end
      end
    end
    if (commit_fire) begin
      in_list_next[commit_old_ptag] = 1'b1;
    end
    err_next = err_reg
             | (commit_fire && (commit_old_ptag == '0 || in_list_reg[commit_old_ptag]))
             | (alloc_req && !alloc_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_list_reg <= {{DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};
      err_reg     <= 1'b0;
    end else begin
      in_list_reg <= in_list_next;
      err_reg     <= err_next;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: queue-based model plus directed scenarios.
module tb_phys_free_list;
  import rv32i_types::*;

  localparam int PTR_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alloc_req = 1'b0;
  logic             alloc_ready;
  ptag_t            alloc_ptag;
  logic             commit_valid = 1'b0;
  logic             commit_has_dest = 1'b0;
  ptag_t            commit_old_ptag = '0;
  logic             flush = 1'b0;
  logic [PTR_W-1:0] free_count;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  phys_free_list dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_ready     (alloc_ready),
    .alloc_ptag      (alloc_ptag),
    .commit_valid    (commit_valid),
    .commit_has_dest (commit_has_dest),
    .commit_old_ptag (commit_old_ptag),
    .flush           (flush),
    .free_count      (free_count),
    .err             (err)
  );

  always #5 clk = ~clk;

  // Model: free_q holds tags available to rename in order; infl_q holds
  // tags handed out but not yet retired, oldest first.
  ptag_t free_q[$];
  ptag_t infl_q[$];
  bit    model_err;
  bit    m_alloc;
  bit    m_in_free;
  ptag_t m_tag;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q.delete();
      infl_q.delete();
      for (int i = 0; i < 32; i++) free_q.push_back(ptag_t'(32 + i));
      model_err = 1'b0;
    end else begin
      m_in_free = 1'b0;
      foreach (free_q[j]) if (free_q[j] == commit_old_ptag) m_in_free = 1'b1;
`ifdef PHYS_FREE_LIST_CHECK_EN
      if (commit_valid && commit_has_dest && (commit_old_ptag == 0 || m_in_free)) model_err = 1'b1;
      if (alloc_req && free_q.size() == 0) model_err = 1'b1;
`endif
      m_alloc = alloc_req && (free_q.size() != 0) && !flush;
      if (m_alloc) begin
        m_tag = free_q.pop_front();
        infl_q.push_back(m_tag);
      end
      if (commit_valid && commit_has_dest) begin
        if (infl_q.size() != 0) void'(infl_q.pop_front());
        free_q.push_back(commit_old_ptag);
      end
      if (flush) begin
        free_q = {infl_q, free_q};
        infl_q.delete();
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_free_count", int'(free_count), free_q.size());
      check("model_alloc_ready", int'(alloc_ready), int'(free_q.size() != 0));
      if (free_q.size() != 0) check("model_alloc_ptag", int'(alloc_ptag), int'(free_q[0]));
      check("model_err", int'(err), int'(model_err));
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic cyc(input bit req, input bit cv, input bit hd, input int tag, input bit fl);
    alloc_req       = req;
    commit_valid    = cv;
    commit_has_dest = hd;
    commit_old_ptag = ptag_t'(tag);
    flush           = fl;
    @(posedge clk);
    #1;
    alloc_req = 1'b0; commit_valid = 1'b0; commit_has_dest = 1'b0;
    commit_old_ptag = '0; flush = 1'b0;
    $display("[TB] cyc req=%0d cv=%0d hd=%0d tag=%0d fl=%0d -> free=%0d ptag=%0d",
             req, cv, hd, tag, fl, free_count, alloc_ptag);
  endtask

  initial begin
    int exp_tag;

    // Reset state
    do_reset();
    check("rst_free_count", int'(free_count), 32);
    check("rst_alloc_ready", int'(alloc_ready), 1);
    check("rst_alloc_ptag", int'(alloc_ptag), 32);
    check("rst_err", int'(err), 0);

    // Drain the list in order, then try one more
    for (int i = 0; i < 32; i++) begin
      check("drain_ptag", int'(alloc_ptag), 32 + i);
      cyc(1, 0, 0, 0, 0);
    end
    check("empty_free_count", int'(free_count), 0);
    check("empty_alloc_ready", int'(alloc_ready), 0);
    cyc(1, 0, 0, 0, 0);
    check("underflow_ignored", int'(free_count), 0);

    // Commit into an empty list; the concurrent alloc gets nothing
    cyc(1, 1, 1, 5, 0);
    check("refill_ready", int'(alloc_ready), 1);
    check("refill_ptag", int'(alloc_ptag), 5);
    check("refill_count", int'(free_count), 1);
    cyc(0, 1, 0, 9, 0);
    check("no_dest_commit", int'(free_count), 1);

    // Alloc 3, commit 1, flush
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 7, 0);
    cyc(0, 0, 0, 0, 1);
    check("flush_count", int'(free_count), 32);
    check("flush_ptag", int'(alloc_ptag), 33);

    // Flush together with commit and an alloc that must be dropped
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 9, 1);
    check("flush_commit_count", int'(free_count), 32);
    check("flush_commit_ptag", int'(alloc_ptag), 33);

    // Paired alloc+commit streaming through wrap-around
    do_reset();
    for (int i = 0; i < 100; i++) begin
      exp_tag = (i < 32) ? 32 + i : ((i - 32) % 31) + 1;
      check("stream_ptag", int'(alloc_ptag), exp_tag);
      cyc(1, 1, 1, (i % 31) + 1, 0);
      check("stream_count", int'(free_count), 32);
    end

`ifdef PHYS_FREE_LIST_CHECK_EN
    do_reset();
    cyc(0, 1, 1, 40, 0);
    check("double_free_err", int'(err), 1);
    cyc(0, 0, 0, 0, 0);
    check("err_sticky", int'(err), 1);
    do_reset();
    check("err_cleared", int'(err), 0);
`endif

    // Asynchronous reset in the middle of traffic
    cyc(1, 0, 0, 0, 0);
    alloc_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", int'(free_count), 32);
    check("async_rst_ptag", int'(alloc_ptag), 32);
    rst_n = 1'b1;
    alloc_req = 1'b0;
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular free list of physical register tags for the renamed pipeline.
- The rename stage pops `dest_phys_new` from it at dispatch.
- The commit stage pushes retired `dest_phys_old` tags back into it. This is the release end of the rename tag stream.
- It keeps a speculative head (allocation) and an architectural head (commit), so a flush can reclaim every tag allocated but not yet committed in one cycle.

Parameters:
- NUM_PHYS, 64, total physical registers.
- NUM_ARCH, 32, architectural registers; p0..p31 are mapped at reset.
- PTAG_W, 6, physical tag width, equal to $clog2(NUM_PHYS).
- DEPTH, NUM_PHYS-NUM_ARCH (32), storage entries.
- PTR_W, $clog2(DEPTH)+1, pointer width including the wrap bit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_req  in  1  rename requests one tag this cycle.
- alloc_ready  out  1  at least one free tag exists (registered count != 0).
- alloc_ptag  out  PTAG_W  tag at the speculative head; valid when alloc_ready.
- commit_valid  in  1  one instruction retires this cycle.
- commit_has_dest  in  1  the retiring instruction wrote a register (dest_arch != 0).
- commit_old_ptag  in  PTAG_W  the retiring instruction's dest_phys_old, to be freed.
- flush  in  1  mispredict or exception recovery; discard speculative allocations.
- free_count  out  PTR_W  number of free tags, tail minus spec_head.
- err  out  1  sticky error flag; meaningful only with the optional feature, else tied 0.

Behaviour:
- Reset (async, rst_n=0):
  - mem[i] = NUM_ARCH+i.
  - spec_head = arch_head = 0.
  - tail = DEPTH, with the wrap bit set.
  - Outputs after reset: free_count=32, alloc_ready=1, alloc_ptag=32, err=0.
  - Reset mid-operation discards all state immediately.
- Allocate:
  - Fires when alloc_req && alloc_ready && !flush.
  - alloc_ptag = mem[spec_head[PTR_W-2:0]] (combinational read); spec_head increments at the clock edge.
  - alloc_req while alloc_ready=0 is ignored; no state change.
- Commit:
  - Fires when commit_valid && commit_has_dest.
  - Writes mem[tail] = commit_old_ptag, then tail+1 and arch_head+1.
  - commit_valid with commit_has_dest=0 does nothing.
- Flush: spec_head <= arch_head as updated by a commit in the same cycle, i.e. arch_head+1 when that commit fires.
- Simultaneous events:
  - Alloc and commit together: both happen, and free_count is unchanged.
  - Alloc with flush: flush wins and the alloc is dropped.
  - Commit with flush: the commit is applied first.
- Invariant: tail - arch_head == DEPTH always, so tail never overruns arch_head.
- Empty:
  - spec_head == tail means alloc_ready=0.
  - No same-cycle bypass: a tag freed at edge N can be allocated from edge N+1.
- Wrap-around: all pointers are modulo 2*DEPTH; the index uses the low PTR_W-1 bits.
- Latency: alloc_ptag is combinational. free_count and alloc_ready update one cycle after a state change.

Optional Feature:
- Macro PHYS_FREE_LIST_CHECK_EN.
- Defined:
  - Adds an NUM_PHYS-bit in_list vector, reset with bits 32..63 set.
  - Allocation clears the popped tag's bit; commit sets the freed tag's bit.
  - err sets and stays set (until reset) on any of:
    - freeing a tag whose bit is already set (double free);
    - freeing p0;
    - alloc_req asserted while alloc_ready=0.
  - Flush restores in_list by setting the bit of every entry between the restored spec_head and tail. This is a loop over DEPTH.
- Undefined: no vector, err tied 0, no added logic.

Decomposition:
- Shared package entry in rv32i_types: `localparam NUM_PHYS=64, NUM_ARCH=32`; `typedef logic [5:0] ptag_t`. Ports use ptag_t.
- No sub-module. The storage is a simple register array inside the block; a separate circular-pointer helper is unnecessary.

Test Plan:
- Reset, then 32 consecutive allocs → tags 32,33,…,63 in order; alloc_ready falls after the 32nd; free_count=0; a 33rd alloc_req is ignored.
- From empty, commit with old_ptag=5 → next cycle alloc_ready=1, alloc_ptag=5, free_count=1; the same-cycle alloc while empty gets nothing.
- Alloc 3 (32,33,34), commit 1 with old_ptag=7, then flush → spec_head = arch_head: free_count=32 and alloc_ptag=33. The tag 32 consumed by the committed instruction stays allocated; 33 and 34 return.
- Flush and commit in the same cycle after 2 allocs → spec_head lands one past the pre-commit arch_head; free_count=32.
- 100 paired alloc+commit cycles cycling tags through wrap → free_count constant 32 and returned tags emerge in FIFO order.
- With PHYS_FREE_LIST_CHECK_EN: commit old_ptag=40 while 40 is still in the list → err=1 next cycle and sticky; re-reset → err=0.
